// File: rtl/toggle_handshake_rx.sv
// Receive side of a two-phase toggle handshake: sync req_tgl, capture, ready/valid out, toggle ack.
// Define TGL_RX_EVENT_CNT_EN to build the transfer event counter; otherwise event_cnt is tied to 0.
module toggle_handshake_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_tgl,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [CNT_W-1:0]  event_cnt,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_sync;
    logic                   req_seen;
    logic                   pending;
    logic                   capture;
    logic                   consume;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl};
    end

    assign req_sync = sync_q[SYNC_STAGES-1];
    assign pending  = req_sync ^ req_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pending) state_nxt = CAPTURE;
            CAPTURE: state_nxt = HOLD;
            HOLD:    if (dout_valid && dout_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        consume = 1'b0;
        unique case (state)
            CAPTURE: capture = 1'b1;
            HOLD:    consume = dout_valid && dout_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_seen   <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ack_tgl    <= 1'b0;
        end else if (capture) begin
            req_seen   <= req_sync;
            dout       <= data_in;
            dout_valid <= 1'b1;
        end else if (consume) begin
            dout_valid <= 1'b0;
            ack_tgl    <= ~ack_tgl;
        end
    end

    // A second toggle seen before the ack is a transmitter protocol violation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            overflow <= 1'b0;
        else if (state == HOLD && pending)  overflow <= 1'b1;
    end

`ifdef TGL_RX_EVENT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          event_cnt <= '0;
        else if (capture) event_cnt <= event_cnt + 1'b1;
    end
`else
    assign event_cnt = '0;
`endif

endmodule

// File: doc/toggle_handshake_rx.md
# toggle_handshake_rx

Receiving end of the two-phase toggle handshake whose transmitter drives a toggle flip-flop (`req_tgl`) from another clock domain. The block synchronizes `req_tgl` and detects each toggle as one transfer request. It captures the accompanying data word, presents it on a ready/valid port to local logic, and returns a toggle acknowledge (`ack_tgl`) once the word is consumed. It sits at the clock-domain boundary on the `clk` side.

## Interface
Parameters:
- `DATA_W`, default 8: width of the transferred word.
- `SYNC_STAGES`, default 2: synchronizer depth for `req_tgl`; legal values ≥ 2.
- `CNT_W`, default 8: width of the transfer event counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_tgl` in 1: request toggle from the transmitter, asynchronous to `clk`. Each level change is one request.
- `data_in` in `DATA_W`: transfer word. Stable from the `req_tgl` change until the transmitter sees the next `ack_tgl` change.
- `ack_tgl` out 1: acknowledge toggle back to the transmitter.
- `dout` out `DATA_W`: captured word.
- `dout_valid` out 1: `dout` holds an unconsumed word.
- `dout_ready` in 1: local consumer accepts `dout`.
- `event_cnt` out `CNT_W`: number of captured transfers.
- `overflow` out 1: sticky protocol-violation flag.

## Operation
- **Synchronizer:** `SYNC_STAGES` flops, all reset to 0. `req_sync` is the last stage.
- **Toggle detection:** `req_seen` holds the last accepted request level and resets to 0. A pending request exists when `req_sync` differs from `req_seen`.
- **FSM states:** IDLE, CAPTURE, HOLD. Reset state is IDLE.
  - IDLE: if a request is pending, go to CAPTURE. Otherwise stay in IDLE.
  - CAPTURE (1 cycle):
    - `dout` ← `data_in`.
    - `dout_valid` ← 1.
    - `req_seen` ← `req_sync`.
    - `event_cnt` increments, wrapping modulo 2^`CNT_W`.
    - Go to HOLD.
  - HOLD: on `dout_valid` && `dout_ready`, set `dout_valid` ← 0, toggle `ack_tgl`, and go to IDLE. Otherwise hold.
- **Overflow:** while in HOLD, if `req_sync` differs from `req_seen`, the transmitter has toggled again before the ack. `overflow` is set and stays 1 until reset. The extra request is not lost: it is serviced after the return to IDLE. Two extra toggles during HOLD cancel each other and are not detected; this is a protocol violation outside the block's responsibility.
- **`dout`:** holds its value after consumption until the next CAPTURE.
- **Reset values:** `ack_tgl`=0, `dout`=0, `dout_valid`=0, `event_cnt`=0, `overflow`=0.
- **Reset mid-operation:** any captured word is dropped and no ack is sent. Both handshake ends must be reset together. If `req_tgl`=1 when `rst` is released, one spurious transfer is captured.

## Timing
- Let edge k be the first `clk` edge that samples the new `req_tgl` level.
  - IDLE→CAPTURE occurs at edge k+`SYNC_STAGES`.
  - `dout_valid` rises at edge k+`SYNC_STAGES`+1, i.e. after 3 edges for the default depth.
- **Ack:** if `dout_ready`=1 while `dout_valid`=1 at edge m, then at edge m `dout_valid` falls and `ack_tgl` toggles. Next request detection is possible from edge m+1.
- **Minimum valid pulse:** `dout_valid` stays high at least 1 cycle. If `dout_ready` is held at 1, a transfer occupies `SYNC_STAGES`+2 local cycles of `clk`, excluding transmitter-side latency.
- **Ready before valid:** `dout_ready` asserted while `dout_valid`=0 has no effect.
- **`overflow` latency:** `overflow` rises 1 cycle after `req_sync` mismatches in HOLD.

## Configuration
- **`TGL_RX_EVENT_CNT_EN` defined:** the `event_cnt` register and its increment logic are built as described in Operation.
- **`TGL_RX_EVENT_CNT_EN` undefined:** `event_cnt` is tied to 0 and no counter logic exists. All other behaviour is identical.

## Test plan
- **Reset values:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately. With `req_tgl`=0 held after release, `dout_valid` stays 0 for 20 cycles.
- **Single transfer:** `data_in`=0xA5, `req_tgl` 0→1, `dout_ready`=1 → `dout`=0xA5 with `dout_valid` high on edge k+3 for 1 cycle. `ack_tgl` becomes 1 on that consuming edge. `event_cnt`=1.
- **Back-pressure:** `dout_ready`=0 for 10 cycles after valid → `dout_valid` and `dout`=0x3C remain stable and `ack_tgl` unchanged. Raise `dout_ready` → ack toggles on that edge.
- **Counter wrap:** 256 transfers with alternating data at `CNT_W`=8 → `event_cnt` returns to 0 and every word is received in order. With `TGL_RX_EVENT_CNT_EN` undefined → `event_cnt` stays 0 throughout.
- **Overflow:** toggle `req_tgl` a second time while in HOLD (`dout_ready`=0) → `overflow`=1 and stays 1. After consumption, the second word is captured as well and `event_cnt`=2.
- **Reset mid-HOLD:** assert `rst` while `dout_valid`=1 → `dout_valid`=0 and `ack_tgl`=0. With `req_tgl` returned to 0 before release, no capture follows.
